// File: rtl/writeback.sv
// W stage of the RV32i pipeline: MEM/WB register, result select, and the integer register file.
// Optional retirement counter is enabled by defining WB_RETIRE_CNT_EN.
module writeback #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  Stall_W,
  input  logic                  Flush_W,
  input  logic                  Valid_M,
  input  logic                  REG_W_En_M,
  input  logic [REG_ADDR_W-1:0] REG_W_Addr_M,
  input  logic [1:0]            WB_Src_M,
  input  logic [DATA_WIDTH-1:0] ALU_Out_M,
  input  logic [DATA_WIDTH-1:0] PC_Plus_4_M,
  input  logic [DATA_WIDTH-1:0] MEM_Out_W,
  input  logic [REG_ADDR_W-1:0] REG_R_Addr1_D,
  input  logic [REG_ADDR_W-1:0] REG_R_Addr2_D,
  output logic [DATA_WIDTH-1:0] REG_R_Data1_D,
  output logic [DATA_WIDTH-1:0] REG_R_Data2_D,
  output logic [DATA_WIDTH-1:0] Result_W,
  output logic                  REG_W_En_W,
  output logic [REG_ADDR_W-1:0] REG_W_Addr_W
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           Retire_Count_W
`endif
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_RSVD = 2'b11
  } wb_src_e;

  logic                  r_valid;
  logic                  r_en;
  logic [REG_ADDR_W-1:0] r_addr;
  wb_src_e               r_src;
  logic [DATA_WIDTH-1:0] r_alu;
  logic [DATA_WIDTH-1:0] r_pc4;
  logic [DATA_WIDTH-1:0] r_mem_hold;
  logic                  r_hold;
  logic [DATA_WIDTH-1:0] r_rf [NUM_REGS];

  logic [DATA_WIDTH-1:0] w_mem_data;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_rf_we;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // MEM/WB pipeline register: reset > flush > stall > load
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_valid <= 1'b0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_src   <= SRC_ALU;
      r_alu   <= '0;
      r_pc4   <= '0;
    end else if (Flush_W) begin
      r_valid <= 1'b0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_src   <= SRC_ALU;
      r_alu   <= '0;
      r_pc4   <= '0;
    end else if (!Stall_W) begin
      r_valid <= Valid_M;
      r_en    <= REG_W_En_M;
      r_addr  <= REG_W_Addr_M;
      r_src   <= wb_src_e'(WB_Src_M);
      r_alu   <= ALU_Out_M;
      r_pc4   <= PC_Plus_4_M;
    end
  end

  // Memory read data is only presented on the first W cycle; keep it across a stall
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_hold     <= 1'b0;
      r_mem_hold <= '0;
    end else if (Flush_W || !Stall_W) begin
      r_hold <= 1'b0;
    end else if (!r_hold) begin
      r_hold     <= 1'b1;
      r_mem_hold <= MEM_Out_W;
    end
  end

  always_comb begin
    w_mem_data = r_hold ? r_mem_hold : MEM_Out_W;
    w_result   = '0;
    unique case (r_src)
      SRC_ALU:  w_result = r_alu;
      SRC_MEM:  w_result = w_mem_data;
      SRC_PC4:  w_result = r_pc4;
      SRC_RSVD: w_result = '0;
    endcase
  end

  assign w_rf_we = r_en & r_valid & (r_addr != '0) & (r_src != SRC_RSVD);

  // Register file; x0 is never written so it always holds zero
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_rf_we) begin
      r_rf[r_addr] <= w_result;
    end
  end

  // Write-through bypass so a same-cycle read sees the value being written
  always_comb begin
    w_rd1 = r_rf[REG_R_Addr1_D];
    w_rd2 = r_rf[REG_R_Addr2_D];
    if (REG_R_Addr1_D == '0) begin
      w_rd1 = '0;
    end else if (w_rf_we && (REG_R_Addr1_D == r_addr)) begin
      w_rd1 = w_result;
    end
    if (REG_R_Addr2_D == '0) begin
      w_rd2 = '0;
    end else if (w_rf_we && (REG_R_Addr2_D == r_addr)) begin
      w_rd2 = w_result;
    end
  end

  assign REG_R_Data1_D = w_rd1;
  assign REG_R_Data2_D = w_rd2;
  assign Result_W      = w_result;
  assign REG_W_En_W    = r_en;
  assign REG_W_Addr_W  = r_addr;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  // Counts instructions leaving W normally; wraps naturally at 2^64
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_retire_cnt <= '0;
    end else if (r_valid && !Stall_W && !Flush_W) begin
      r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  assign Retire_Count_W = r_retire_cnt;
`endif

endmodule
